// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and constants for the alu_arb issue controller.
//   arb_state_t : arbitration FSM states (ARB, OWN0, OWN1)
//   req_id_t    : requester id (0 = main decode, 1 = microsequencer)
//   COP_NOP     : opcode driven to alu_stage on idle cycles
//   ALU_*_W     : widths shared with alu_stage
package alu_arb_pkg;

    localparam int ALU_DATA_W = 16;
    localparam int ALU_COP_W  = 4;
    localparam int ALU_ADDR_W = 3;
    localparam int ALU_IMM_W  = 9;

    localparam logic [ALU_COP_W-1:0] COP_NOP = '0;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational two-way picker.
//   valid0_i/valid1_i : request valids
//   ptr_i             : requester holding priority when both are valid in ARB
//   state_i           : owner state; OWNn restricts the grant to requester n
//   block_i           : forces no grant (stall or reset)
//   grant_o           : one-hot grant, only ever set for a valid requester
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  req_id_t    ptr_i,
    input  arb_state_t state_i,
    input  logic       block_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (!block_i) begin
            case (state_i)
                OWN0:    grant_o[0] = valid0_i;
                OWN1:    grant_o[1] = valid1_i;
                default: begin
                    if (valid0_i && valid1_i) begin
                        grant_o[ptr_i] = 1'b1;
                    end else begin
                        grant_o = {valid1_i, valid0_i};
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two-requester arbiter / issue controller in front of alu_stage.
//   clk, reset (async, active-high)
//   reqN_*      : valid/ready request channel with operands, opcode, dest,
//                 we, immediate and lock (N = 0, 1)
//   alu_stall   : freezes arbitration state and the ALU stage
//   regA..inmediate, enable_alu : issue ports into alu_stage
//   alu_result, OVF, destReg_addr_output, we_output : alu_stage outputs
//   rsp_*       : result, tagged with the issuing requester, one cycle after issue
// Build option: ALU_ARB_RR_EN selects round-robin priority; without it
// requester 0 wins ARB contention except right after a forced release.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W   = ALU_DATA_W,
    parameter int COP_W    = ALU_COP_W,
    parameter int ADDR_W   = ALU_ADDR_W,
    parameter int IMM_W    = ALU_IMM_W,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_regA,
    input  logic [DATA_W-1:0] req0_regB,
    input  logic [COP_W-1:0]  req0_cop,
    input  logic [ADDR_W-1:0] req0_destReg_addr,
    input  logic              req0_we,
    input  logic [IMM_W-1:0]  req0_inmediate,
    input  logic              req0_lock,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_regA,
    input  logic [DATA_W-1:0] req1_regB,
    input  logic [COP_W-1:0]  req1_cop,
    input  logic [ADDR_W-1:0] req1_destReg_addr,
    input  logic              req1_we,
    input  logic [IMM_W-1:0]  req1_inmediate,
    input  logic              req1_lock,
    input  logic              alu_stall,
    output logic [DATA_W-1:0] regA,
    output logic [DATA_W-1:0] regB,
    output logic [COP_W-1:0]  cop,
    output logic [ADDR_W-1:0] destReg_addr,
    output logic              we,
    output logic [IMM_W-1:0]  inmediate,
    output logic              enable_alu,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              OVF,
    input  logic [ADDR_W-1:0] destReg_addr_output,
    input  logic              we_output,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_ovf,
    output logic [ADDR_W-1:0] rsp_destReg_addr,
    output logic              rsp_we
);

    localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

    arb_state_t       state_q, state_d;
    req_id_t          ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             issue_v_q, issue_v_d;
    req_id_t          issue_id_q, issue_id_d;

    logic [1:0] grant;
    logic       hs;
    req_id_t    gid;
    logic       forced;

    alu_arb_pick u_pick (
        .valid0_i (req0_valid),
        .valid1_i (req1_valid),
        .ptr_i    (ptr_q),
        .state_i  (state_q),
        .block_i  (alu_stall | reset),
        .grant_o  (grant)
    );

    assign hs  = |grant;
    assign gid = grant[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            issue_v_q  <= 1'b0;
            issue_id_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            issue_v_q  <= issue_v_d;
            issue_id_q <= issue_id_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        forced     = 1'b0;
        issue_v_d  = hs & ~alu_stall;
        issue_id_d = gid;

        if (!alu_stall) begin
            case (state_q)
                ARB: begin
                    if (grant[0] && req0_lock) begin
                        state_d = OWN0;
                        cnt_d   = '0;
                    end else if (grant[1] && req1_lock) begin
                        state_d = OWN1;
                        cnt_d   = '0;
                    end
                end
                OWN0: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                        forced  = 1'b1;
                    end else if (!req0_lock) begin
                        state_d = ARB;
                    end
                end
                OWN1: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                        forced  = 1'b1;
                    end else if (!req1_lock) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase

`ifdef ALU_ARB_RR_EN
            if (hs) begin
                ptr_d = other_id(gid);
            end
`else
            // Priority handed out by a forced release lasts for one ARB grant.
            if (hs && state_q == ARB) begin
                ptr_d = 1'b0;
            end
`endif
            // Forced release always hands priority to the requester that was locked out.
            if (forced) begin
                ptr_d = other_id(state_q == OWN1);
            end
        end
    end

    always_comb begin
        req0_ready   = grant[0];
        req1_ready   = grant[1];
        regA         = '0;
        regB         = '0;
        cop          = COP_W'(COP_NOP);
        destReg_addr = '0;
        we           = 1'b0;
        inmediate    = '0;
        if (grant[0]) begin
            regA         = req0_regA;
            regB         = req0_regB;
            cop          = req0_cop;
            destReg_addr = req0_destReg_addr;
            we           = req0_we;
            inmediate    = req0_inmediate;
        end else if (grant[1]) begin
            regA         = req1_regA;
            regB         = req1_regB;
            cop          = req1_cop;
            destReg_addr = req1_destReg_addr;
            we           = req1_we;
            inmediate    = req1_inmediate;
        end
    end

    assign enable_alu       = ~alu_stall;
    assign rsp_valid        = issue_v_q;
    assign rsp_id           = issue_id_q;
    assign rsp_result       = alu_result;
    assign rsp_ovf          = OVF;
    assign rsp_destReg_addr = destReg_addr_output;
    assign rsp_we           = we_output;

endmodule
